data_mem_model_pipe: RTL and testbench
======================================

Name: data_mem_model_pipe

Overview:
- Parametrised, pipelined successor of the single-outstanding DV data memory model, used in the cheriot DV testbench.
- Serves an OBI-style data port with up to MAX_OUTSTANDING in-order transactions.
- Grant and response wait states come from a seeded LFSR, so runs are reproducible. No $urandom is used.
- Supports configurable word width (optional tag bit), memory depth, base address, address-range errors and optional error injection.

Parameters:
- DW, 33, word width in bits. When DW==33, bit 32 is the capability tag; 32 means no tag.
- AW, 16, word-address bits (memory holds 2**AW words).
- BASE_ADDR, 32'h8000_0000, byte base address; must be aligned to 2**(AW+2).
- MAX_OUTSTANDING, 4, response FIFO depth (1..8).
- LFSR_SEED, 16'hACE1, LFSR reset value; 0 is replaced by 16'h0001.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- gnt_wmax  in  4  maximum grant wait cycles
- resp_wmax  in  4  maximum response wait cycles
- err_rate  in  3  error injection rate; 0 = off
- err_enable  in  1  global error injection enable
- data_req  in  1  request valid
- data_we  in  1  write
- data_be  in  4  byte enables
- data_addr  in  32  byte address
- data_wdata  in  DW  write data (with tag when DW==33)
- data_gnt  out  1  grant
- data_rvalid  out  1  response valid, one-cycle pulse
- data_rdata  out  DW  read data
- data_err  out  1  response error
- outstanding  out  4  transactions accepted but not yet responded

Behaviour:
- Reset: all control resets on posedge clk with rst=1.
  - data_gnt=0, data_rvalid=0, data_rdata=0, data_err=0, outstanding=0.
  - FIFO empty, wait counters 0, LFSR=LFSR_SEED.
  - Memory array is not reset.
  - Reset mid-operation drops all pending transactions; no rvalid is issued for them.
- LFSR: 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1. Advances every cycle while not in reset.
- Grant:
  - On the first cycle of a new request (data_req=1, gnt wait idle), load gwait = lfsr % (gnt_wmax+1).
  - Decrement gwait each cycle while the request is held.
  - data_gnt = data_req & gwait==0 & outstanding<MAX_OUTSTANDING (combinational). With gnt_wmax=0 and FIFO not full, gnt is asserted in the same cycle as req.
  - Full: gnt=0 even if a retire happens that cycle (no bypass).
  - The requester must hold req/addr/we/be/wdata stable until gnt.
- Accept (data_req & data_gnt):
  - in_range = data_addr[31:AW+2] == BASE_ADDR[31:AW+2].
  - inj = err_enable & err_rate!=0 & lfsr[7-err_rate:0]==0.
  - err = ~in_range | inj.
  - Write with ~err: update bytes per data_be in the accept cycle. When DW==33, tag = (data_be==4'hF) ? wdata[32] : 0, written only if |data_be.
  - Read with ~err: capture mem[addr[AW+1:2]] in the accept cycle, so read-after-write order follows accept order.
  - An errored access never modifies memory. Its rdata is 0.
  - Push {rdata, err} into the FIFO. Write responses carry rdata=0.
- Response:
  - When an entry becomes head, load rwait = lfsr % (resp_wmax+1).
  - When rwait==0, pop the head and drive data_rvalid=1 with data_rdata/data_err registered for exactly one cycle; otherwise data_rvalid=0 and data_rdata/err=0.
  - No backpressure. Minimum latency is accept at cycle N, rvalid at N+1. Responses stay in order.
  - Back-to-back responses are allowed when resp_wmax=0.
- Counters: push and pop in the same cycle leave outstanding unchanged. Pop is only possible when the FIFO is non-empty. Read and write pointers wrap modulo MAX_OUTSTANDING.

Optional Feature:
- DMEM_ERR_INJECT_EN: when defined, LFSR error injection is active as described above.
- When undefined, inj=0; err_rate and err_enable are ignored and errors come only from out-of-range accesses.

Decomposition:
- cheriot_dv_pkg holds:
  - typedef dmem_rsp_t {logic [32:0] rdata; logic err;}
  - DMEM_LFSR_POLY = 16'hB400
  - DMEM_MAX_OUTSTANDING_LIMIT = 8
- One sub-module: dmem_rsp_fifo, a parametrised depth/width in-order FIFO with push, pop, count, full and empty.

Test Plan:
- gnt_wmax=0, resp_wmax=0; write 0x8000_0010 wdata=33'h1_DEADBEEF be=F, then read it -> gnt in the req cycle; read rvalid 1 cycle after accept; rdata=33'h1_DEADBEEF, err=0.
- Partial write be=4'b0011 wdata=33'h1_0000_1234 to a word holding 33'h1_AAAA_5555, then read -> rdata=33'h0_AAAA_1234 (tag cleared).
- Read 0x9000_0000 (out of range) -> rvalid with err=1, rdata=0; following read of 0x8000_0000 unaffected, err=0.
- MAX_OUTSTANDING=4, resp_wmax=15; issue 6 back-to-back reads -> outstanding peaks at 4, gnt low while full; 6 responses returned in issue order with correct data.
- With DMEM_ERR_INJECT_EN, err_enable=1, err_rate=7, 256 writes -> about 50% err=1, and errored writes leave memory unchanged on read-back; err_enable=0 -> zero errors.
- Assert rst with 3 outstanding -> no rvalid after reset; outstanding=0, gnt=0; same seed reproduces an identical gnt/rvalid cycle trace.

Source files
------------

// File: rtl/cheriot_dv_pkg.sv
// rtl/cheriot_dv_pkg.sv - shared response type, LFSR constants and helpers for the DV data memory model
package cheriot_dv_pkg;

   typedef struct packed {
      logic [32:0] rdata;
      logic        err;
   } dmem_rsp_t;

   localparam logic [15:0] DMEM_LFSR_POLY             = 16'hB400;
   localparam int          DMEM_MAX_OUTSTANDING_LIMIT = 8;

   // Right-shifting Galois form of x^16+x^14+x^13+x^11+1
   function automatic logic [15:0] lfsr_step(input logic [15:0] s);
      return s[0] ? ((s >> 1) ^ DMEM_LFSR_POLY) : (s >> 1);
   endfunction

   function automatic logic [3:0] wait_pick(input logic [15:0] s, input logic [3:0] wmax);
      return 4'(s % ({12'd0, wmax} + 16'd1));
   endfunction

endpackage

// File: rtl/dmem_rsp_fifo.sv
// rtl/dmem_rsp_fifo.sv - in-order response FIFO with occupancy count, full and empty
module dmem_rsp_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 34
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic [W-1:0] push_data,
   input  logic         pop,
   output logic [W-1:0] head,
   output logic [3:0]   count,
   output logic         full,
   output logic         empty
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [W-1:0]  store [DEPTH];
   logic [PW-1:0] wptr;
   logic [PW-1:0] rptr;
   logic          do_push;
   logic          do_pop;

   function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign full    = (count == 4'(DEPTH));
   assign empty   = (count == 4'd0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign head    = store[rptr];

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= 4'd0;
      end else begin
         if (do_push) begin
            store[wptr] <= push_data;
            wptr        <= bump(wptr);
         end
         if (do_pop) begin
            rptr <= bump(rptr);
         end
         if (do_push & ~do_pop) begin
            count <= count + 4'd1;
         end else if (do_pop & ~do_push) begin
            count <= count - 4'd1;
         end
      end
   end

endmodule

// File: rtl/data_mem_model_pipe.sv
// rtl/data_mem_model_pipe.sv - pipelined OBI data memory model with LFSR wait states; DMEM_ERR_INJECT_EN enables error injection
module data_mem_model_pipe
   import cheriot_dv_pkg::*;
#(
   parameter int          DW              = 33,
   parameter int          AW              = 16,
   parameter logic [31:0] BASE_ADDR       = 32'h8000_0000,
   parameter int          MAX_OUTSTANDING = 4,
   parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [3:0]    gnt_wmax,
   input  logic [3:0]    resp_wmax,
   input  logic [2:0]    err_rate,
   input  logic          err_enable,
   input  logic          data_req,
   input  logic          data_we,
   input  logic [3:0]    data_be,
   input  logic [31:0]   data_addr,
   input  logic [DW-1:0] data_wdata,
   output logic          data_gnt,
   output logic          data_rvalid,
   output logic [DW-1:0] data_rdata,
   output logic          data_err,
   output logic [3:0]    outstanding
);

   localparam int DEPTH = (MAX_OUTSTANDING < 1) ? 1 :
                          (MAX_OUTSTANDING > DMEM_MAX_OUTSTANDING_LIMIT) ? DMEM_MAX_OUTSTANDING_LIMIT :
                          MAX_OUTSTANDING;
   localparam logic [15:0] SEED   = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
   localparam bit          TAGGED = (DW == 33);

   logic [15:0]   lfsr;
   logic          gw_busy;
   logic [3:0]    gw_q;
   logic [3:0]    gw_cur;
   logic          rw_busy;
   logic [3:0]    rw_q;
   logic [3:0]    rw_cur;
   logic          in_range;
   logic          inj;
   logic          err;
   logic          accept;
   logic          pop;
   logic          full;
   logic          empty;
   logic [3:0]    count;
   logic [AW-1:0] word_idx;
   logic [DW-1:0] mem [2**AW];
   logic [DW-1:0] cur_word;
   logic [DW-1:0] wr_word;
   dmem_rsp_t     push_rsp;
   dmem_rsp_t     head_rsp;
   logic          unused_bits;

   always_ff @(posedge clk) begin
      if (rst) lfsr <= SEED;
      else     lfsr <= lfsr_step(lfsr);
   end

   // The first cycle of a request uses the freshly drawn wait; later cycles use the held countdown
   assign gw_cur   = gw_busy ? gw_q : wait_pick(lfsr, gnt_wmax);
   assign data_gnt = ~rst & data_req & (gw_cur == 4'd0) & ~full;
   assign accept   = data_req & data_gnt;

   always_ff @(posedge clk) begin
      if (rst | ~data_req | data_gnt) begin
         gw_busy <= 1'b0;
         gw_q    <= 4'd0;
      end else begin
         gw_busy <= 1'b1;
         gw_q    <= (gw_cur == 4'd0) ? 4'd0 : gw_cur - 4'd1;
      end
   end

   assign in_range = (data_addr[31:AW+2] == BASE_ADDR[31:AW+2]);
   assign word_idx = data_addr[AW+1:2];

`ifdef DMEM_ERR_INJECT_EN
   assign inj         = err_enable & (err_rate != 3'd0) & ((lfsr[7:0] & (8'hFF >> err_rate)) == 8'h00);
   assign unused_bits = ^data_addr[1:0];
`else
   assign inj         = 1'b0;
   assign unused_bits = ^{data_addr[1:0], err_rate, err_enable};
`endif

   assign err      = ~in_range | inj;
   assign cur_word = mem[word_idx];

   always_comb begin
      wr_word = cur_word;
      for (int b = 0; b < 4; b++) begin
         if (data_be[b]) wr_word[8*b +: 8] = data_wdata[8*b +: 8];
      end
      // Tag survives only a full-word store; any narrower store clears it
      if (TAGGED && (data_be != 4'h0)) begin
         wr_word[DW-1] = (data_be == 4'hF) ? data_wdata[DW-1] : 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (accept & data_we & ~err) mem[word_idx] <= wr_word;
   end

   assign push_rsp.rdata = (accept & ~data_we & ~err) ? 33'(cur_word) : 33'd0;
   assign push_rsp.err   = err;

   dmem_rsp_fifo #(
      .DEPTH (DEPTH),
      .W     ($bits(dmem_rsp_t))
   ) u_rsp_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (accept),
      .push_data (push_rsp),
      .pop       (pop),
      .head      (head_rsp),
      .count     (count),
      .full      (full),
      .empty     (empty)
   );

   assign rw_cur = rw_busy ? rw_q : wait_pick(lfsr, resp_wmax);
   assign pop    = ~rst & ~empty & (rw_cur == 4'd0);

   always_ff @(posedge clk) begin
      if (rst | pop | empty) begin
         rw_busy <= 1'b0;
         rw_q    <= 4'd0;
      end else begin
         rw_busy <= 1'b1;
         rw_q    <= rw_cur - 4'd1;
      end
   end

   assign data_rvalid = pop;
   assign data_rdata  = pop ? head_rsp.rdata[DW-1:0] : '0;
   assign data_err    = pop & head_rsp.err;
   assign outstanding = count;

endmodule

// File: tb/tb_data_mem_model_pipe.sv
// tb/tb_data_mem_model_pipe.sv - self-checking bench for data_mem_model_pipe against a transaction-level reference
`timescale 1ns/1ps
module tb_data_mem_model_pipe;

   localparam int          DW   = 33;
   localparam int          AW   = 16;
   localparam int          MAXO = 4;
   localparam logic [31:0] BASE = 32'h8000_0000;

   logic          clk = 1'b0;
   logic          rst;
   logic [3:0]    gnt_wmax, resp_wmax;
   logic [2:0]    err_rate;
   logic          err_enable;
   logic          data_req, data_we;
   logic [3:0]    data_be;
   logic [31:0]   data_addr;
   logic [DW-1:0] data_wdata;
   logic          data_gnt, data_rvalid, data_err;
   logic [DW-1:0] data_rdata;
   logic [3:0]    outstanding;

   always #5 clk = ~clk;

   data_mem_model_pipe #(
      .DW(DW), .AW(AW), .BASE_ADDR(BASE), .MAX_OUTSTANDING(MAXO), .LFSR_SEED(16'hACE1)
   ) dut (
      .clk(clk), .rst(rst), .gnt_wmax(gnt_wmax), .resp_wmax(resp_wmax),
      .err_rate(err_rate), .err_enable(err_enable), .data_req(data_req),
      .data_we(data_we), .data_be(data_be), .data_addr(data_addr),
      .data_wdata(data_wdata), .data_gnt(data_gnt), .data_rvalid(data_rvalid),
      .data_rdata(data_rdata), .data_err(data_err), .outstanding(outstanding)
   );

   typedef struct {
      logic [32:0] rdata;
      logic        err;
      logic        err_x;
      logic        defer;
      int          idx;
      logic [32:0] wword;
      int          acc_cyc;
   } exp_t;

   exp_t        sb[$];
   logic [32:0] ref_mem[int];
   logic [1:0]  trace_q[$];
   logic [1:0]  trace1[$];
   int          pool[8] = '{0, 1, 2, 5, 100, 4095, 65534, 65535};
   int          errors = 0, checks = 0, cyc = 0, model_out = 0, peak = 0, err_seen = 0;
   bit          inj_on = 0, recording = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [32:0] merge(input logic [32:0] old, input logic [3:0] be, input logic [32:0] wd);
      logic [32:0] r = old;
      for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
      if (be == 4'hF) r[32] = wd[32];
      else if (be != 4'h0) r[32] = 1'b0;
      return r;
   endfunction

   // One clock: inputs are already set; sample at posedge+2, then advance to next posedge+1
   task automatic step(output bit acc, output bit was_full);
      exp_t        e;
      logic [31:0] off;
      #1;
      was_full = (model_out == MAXO);
      check("outstanding", outstanding, model_out);
      if (was_full) check("gnt_while_full", data_gnt, 0);
      if (recording) trace_q.push_back({data_gnt, data_rvalid});
      if (data_rvalid) begin
         if (sb.size() == 0) begin
            check("spurious_rvalid", data_rvalid, 0);
         end else begin
            e = sb.pop_front();
            model_out--;
            check("rdata", data_rdata, e.rdata);
            if (!e.err_x) check("err", data_err, e.err);
            if (e.defer && !data_err) ref_mem[e.idx] = e.wword;
            if (resp_wmax == 0) check("latency", cyc - e.acc_cyc, 1);
            else check("latency_min", (cyc - e.acc_cyc) >= 1, 1);
         end
         if (data_err) err_seen++;
      end else begin
         check("idle_rsp", {data_err, data_rdata}, 0);
      end
      acc = data_req && data_gnt;
      if (acc) begin
         off       = data_addr - BASE;
         e.acc_cyc = cyc;
         e.idx     = int'(off >> 2);
         e.err     = (off >= 32'h0004_0000);
         e.err_x   = !e.err && inj_on;
         e.defer   = e.err_x && data_we;
         e.rdata   = '0;
         e.wword   = '0;
         if (!e.err) begin
            if (data_we) begin
               e.wword = merge(ref_mem.exists(e.idx) ? ref_mem[e.idx] : 33'd0, data_be, data_wdata);
               if (!e.defer) ref_mem[e.idx] = e.wword;
            end else begin
               e.rdata = ref_mem.exists(e.idx) ? ref_mem[e.idx] : 'x;
            end
         end
         sb.push_back(e);
         model_out++;
      end
      if (model_out > peak) peak = model_out;
      cyc++;
      @(posedge clk); #1;
   endtask

   task automatic issue(input bit we, input logic [3:0] be, input logic [31:0] addr, input logic [32:0] wd);
      bit acc, full;
      int waits = 0, n = 0;
      data_req = 1; data_we = we; data_be = be; data_addr = addr; data_wdata = wd;
      do begin
         step(acc, full);
         if (!acc && !full) waits++;
         n++;
      end while (!acc && n < 200);
      check("gnt_timeout", acc, 1);
      check("gnt_wait_bound", waits <= int'(gnt_wmax), 1);
      data_req = 0;
   endtask

   task automatic idle(input int n);
      bit acc, full;
      data_req = 0;
      repeat (n) step(acc, full);
   endtask

   task automatic drain();
      bit acc, full;
      int n = 0;
      data_req = 0;
      while (sb.size() != 0 && n < 300) begin
         step(acc, full);
         n++;
      end
      check("drain_timeout", sb.size(), 0);
   endtask

   task automatic do_reset();
      rst = 1; data_req = 0;
      @(posedge clk); #1;
      rst = 0; sb.delete(); model_out = 0;
      #1;
      check("rst_gnt", data_gnt, 0);
      check("rst_rvalid", data_rvalid, 0);
      check("rst_rdata", data_rdata, 0);
      check("rst_err", data_err, 0);
      check("rst_outstanding", outstanding, 0);
      @(posedge clk); #1;
   endtask

   task automatic trace_run();
      gnt_wmax = 7; resp_wmax = 7;
      do_reset();
      trace_q.delete();
      recording = 1;
      for (int i = 0; i < 12; i++) issue(0, 4'hF, BASE + 32'(pool[i % 8] * 4), '0);
      drain();
      recording = 0;
   endtask

   initial begin
      int mism;
      rst = 1; data_req = 0; data_we = 0; data_be = 0; data_addr = 0; data_wdata = 0;
      gnt_wmax = 0; resp_wmax = 0; err_rate = 0; err_enable = 0;
      do_reset();

      // Full write then read-back with zero wait states
      issue(1, 4'hF, 32'h8000_0010, 33'h1_DEADBEEF);
      issue(0, 4'hF, 32'h8000_0010, '0);
      idle(2);

      // Partial writes clear the tag; an empty byte mask changes nothing
      issue(1, 4'hF,    32'h8000_0020, 33'h1_AAAA5555);
      issue(1, 4'b0011, 32'h8000_0020, 33'h1_00001234);
      issue(0, 4'hF,    32'h8000_0020, '0);
      issue(1, 4'h0,    32'h8000_0020, 33'h1_FFFFFFFF);
      issue(0, 4'hF,    32'h8000_0020, '0);

      // Address range edges; out-of-range writes must not alias into memory
      issue(1, 4'hF, 32'h8000_0000, 33'h0_12345678);
      issue(0, 4'hF, 32'h9000_0000, '0);
      issue(0, 4'hF, 32'h8000_0000, '0);
      issue(1, 4'hF, 32'h9000_0010, 33'h0_BADBAD00);
      issue(0, 4'hF, 32'h8000_0010, '0);
      issue(1, 4'hF, 32'h8003_FFFC, 33'h1_CAFEF00D);
      issue(0, 4'hF, 32'h8003_FFFC, '0);
      issue(0, 4'hF, 32'h8004_0000, '0);
      issue(0, 4'hF, 32'h7FFF_FFFC, '0);
      drain();

      for (int i = 0; i < 8; i++) issue(1, 4'hF, BASE + 32'(pool[i] * 4), {1'($urandom_range(0, 1)), 32'($urandom)});
      drain();

      // Six back-to-back reads against a four-deep response queue
      resp_wmax = 15;
      peak = 0;
      for (int a = 0; a < 8 && peak < MAXO; a++) begin
         peak = 0;
         for (int i = 0; i < 6; i++) issue(0, 4'hF, BASE + 32'(pool[i] * 4), '0);
         drain();
      end
      check("peak_outstanding", peak, MAXO);

      for (int b = 0; b < 6; b++) begin
         gnt_wmax  = 4'($urandom_range(0, 15));
         resp_wmax = 4'($urandom_range(0, 15));
         for (int i = 0; i < 30; i++) begin
            logic [31:0] addr;
            if ($urandom_range(0, 9) == 0) addr = 32'h9000_0000 | ($urandom & 32'h0FFF_FFFC);
            else addr = BASE + 32'(pool[$urandom_range(0, 7)] * 4);
            issue(1'($urandom_range(0, 1)), 4'($urandom), addr, {1'($urandom_range(0, 1)), 32'($urandom)});
         end
         drain();
      end

      // Error injection over 256 distinct words, then read-back
      gnt_wmax = 0; resp_wmax = 0;
      for (int i = 0; i < 256; i++) issue(1, 4'hF, BASE + 32'((1000 + i) * 4), 33'(i));
      drain();
      err_enable = 1; err_rate = 7; err_seen = 0;
`ifdef DMEM_ERR_INJECT_EN
      inj_on = 1;
`endif
      for (int i = 0; i < 256; i++) issue(1, 4'hF, BASE + 32'((1000 + i) * 4), 33'h1_0000_0000 | 33'(~i));
      drain();
`ifdef DMEM_ERR_INJECT_EN
      check("inj_err_fraction", (err_seen >= 64) && (err_seen <= 192), 1);
`else
      check("inj_err_disabled", err_seen, 0);
`endif
      inj_on = 0; err_enable = 0;
      for (int i = 0; i < 256; i++) issue(0, 4'hF, BASE + 32'((1000 + i) * 4), '0);
      drain();
      err_seen = 0;
      for (int i = 0; i < 32; i++) issue(1, 4'hF, BASE + 32'((1000 + i) * 4), 33'(i * 3));
      drain();
      check("err_enable_off", err_seen, 0);
      err_rate = 0;

      // Reset with transactions in flight drops their responses
      gnt_wmax = 0; resp_wmax = 15;
      for (int i = 0; i < 40 && model_out < 3; i++) issue(0, 4'hF, BASE + 32'(pool[i % 8] * 4), '0);
      #1;
      check("pre_reset_outstanding", outstanding, 3);
      @(posedge clk); #1;
      do_reset();
      idle(20);

      // Same seed, same stimulus: identical gnt/rvalid trace
      trace_run();
      trace1 = trace_q;
      trace_run();
      check("trace_len", trace_q.size(), trace1.size());
      mism = 0;
      for (int i = 0; i < trace1.size() && i < trace_q.size(); i++) if (trace1[i] !== trace_q[i]) mism++;
      check("trace_match", mism, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
